ssd_scan_driver: RTL and testbench

//   Time-multiplexed driver for the 4-digit common-anode seven-segment display: takes four hex nibbles

---
 rtl/ssd_scan_driver_pkg.sv | 18 +
 rtl/ssd_hex_decode.sv | 9 +
 rtl/ssd_scan_driver.sv | 90 +++++++++
 tb/tb_ssd_scan_driver.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ssd_scan_driver_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment codes are {a,b,c,d,e,f,g}, active-low.
package ssd_scan_driver_pkg;
   localparam int         NUM_DIGITS = 4;
   localparam logic [6:0] SEG_OFF    = 7'h7F;

   // Index 0 is the right-most entry of the concatenation: 0..F.
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
      7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
   };

   typedef struct packed {
      logic [NUM_DIGITS-1:0][3:0] digits;
      logic [NUM_DIGITS-1:0]      blank;
      logic [NUM_DIGITS-1:0]      dp;
   } disp_t;
endpackage

// File: rtl/ssd_hex_decode.sv
// Hex nibble to active-low seven-segment code, purely combinational.
module ssd_hex_decode
   import ssd_scan_driver_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);
   assign seg = HEX_SEG[nib];
endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed display driver with a shadow/active double buffer
// that only swaps on a frame boundary.
module ssd_scan_driver
   import ssd_scan_driver_pkg::*;
#(
   parameter int DIV_WIDTH    = 18,
   parameter int BLANK_CYCLES = 256
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] digits_in,
   input  logic [3:0]  blank_in,
   input  logic [3:0]  dp_in,
   input  logic        load,
   output logic        load_ack,
   output logic        ca,
   output logic        cb,
   output logic        cc,
   output logic        cd,
   output logic        ce,
   output logic        cf,
   output logic        cg,
   output logic        dp,
   output logic [3:0]  an
);
   localparam logic [DIV_WIDTH-1:0] BLANK_TH = DIV_WIDTH'(BLANK_CYCLES);

   logic [DIV_WIDTH-1:0]        div_cnt;
   logic [1:0]                  digit_idx;
   disp_t                       shadow, active, load_val;
   logic                        pending;
   logic [NUM_DIGITS-1:0][6:0]  dig_seg;
   logic                        wrap, frame_end, slot_lit;
   logic [3:0]                  an_nxt;
   logic [6:0]                  seg_nxt, seg_q;
   logic                        dp_nxt;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
      ssd_hex_decode u_dec (.nib(active.digits[g]), .seg(dig_seg[g]));
   end

   assign load_val  = {digits_in, blank_in, dp_in};
   assign wrap      = &div_cnt;
   assign frame_end = wrap && (digit_idx == 2'd3);

   // First BLANK_CYCLES of each slot stay dark so the previous digit cannot ghost.
   always_comb begin
      slot_lit = (div_cnt >= BLANK_TH) && !active.blank[digit_idx];
      an_nxt   = 4'hF;
      seg_nxt  = SEG_OFF;
      dp_nxt   = 1'b1;
      if (slot_lit) begin
         an_nxt  = ~(4'b0001 << digit_idx);
         seg_nxt = dig_seg[digit_idx];
         dp_nxt  = ~active.dp[digit_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         div_cnt   <= '0;
         digit_idx <= '0;
         shadow    <= '0;
         active    <= '{digits: '0, blank: '1, dp: '0};
         pending   <= 1'b0;
         load_ack  <= 1'b0;
         an        <= 4'hF;
         seg_q     <= SEG_OFF;
         dp        <= 1'b1;
      end else begin
         div_cnt  <= div_cnt + 1'b1;
         if (wrap) digit_idx <= digit_idx + 2'd1;
         load_ack <= frame_end && pending;
         if (frame_end && pending) begin
            active  <= shadow;
            pending <= 1'b0;
         end
         // A load coinciding with the transfer lands after it and waits a frame.
         if (load) begin
            shadow  <= load_val;
            pending <= 1'b1;
         end
         an    <= an_nxt;
         seg_q <= seg_nxt;
         dp    <= dp_nxt;
      end
   end

   assign {ca, cb, cc, cd, ce, cf, cg} = seg_q;
endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench: a time-based reference model pushes the expected pin state
// each cycle; a monitor pops and compares on the falling edge.
module tb_ssd_scan_driver;
   localparam int SLOT  = 16;
   localparam int FRAME = 64;
   localparam int BLNK  = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] digits_in = '0;
   logic [3:0]  blank_in = '0;
   logic [3:0]  dp_in = '0;
   logic        load = 1'b0;
   logic        load_ack, ca, cb, cc, cd, ce, cf, cg, dp;
   logic [3:0]  an;

   ssd_scan_driver #(.DIV_WIDTH(4), .BLANK_CYCLES(BLNK)) dut (
      .clk(clk), .reset_n(reset_n), .digits_in(digits_in), .blank_in(blank_in),
      .dp_in(dp_in), .load(load), .load_ack(load_ack), .ca(ca), .cb(cb), .cc(cc),
      .cd(cd), .ce(ce), .cf(cf), .cg(cg), .dp(dp), .an(an)
   );

   always #5 clk = ~clk;

   logic [6:0] seg_tbl [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

   int checks = 0;
   int errors = 0;
   int ack_cnt = 0;

   // Reference model: k = number of clock edges since reset released.
   int          k = 0;
   logic [15:0] m_act_dig = '0, m_sh_dig = '0;
   logic [3:0]  m_act_blank = 4'hF, m_sh_blank = '0, m_act_dp = '0, m_sh_dp = '0;
   bit          m_pend = 1'b0;
   logic [12:0] exp_q [$];

   always @(posedge clk) begin
      logic [12:0] e;
      int slot, pos;
      bit lit, ack;
      if (!reset_n) begin
         k = 0; m_act_dig = '0; m_act_blank = 4'hF; m_act_dp = '0;
         m_sh_dig = '0; m_sh_blank = '0; m_sh_dp = '0; m_pend = 1'b0;
         e = {1'b0, 4'hF, 7'h7F, 1'b1};
      end else begin
         slot = (k / SLOT) % 4;
         pos  = k % SLOT;
         lit  = (pos >= BLNK) && !m_act_blank[slot];
         ack  = ((k % FRAME) == FRAME - 1) && m_pend;
         if (lit)
            e = {ack, 4'hF & ~(4'(1) << slot), seg_tbl[m_act_dig[slot*4 +: 4]], ~m_act_dp[slot]};
         else
            e = {ack, 4'hF, 7'h7F, 1'b1};
         if (ack) begin
            m_act_dig = m_sh_dig; m_act_blank = m_sh_blank; m_act_dp = m_sh_dp; m_pend = 1'b0;
         end
         if (load) begin
            m_sh_dig = digits_in; m_sh_blank = blank_in; m_sh_dp = dp_in; m_pend = 1'b1;
         end
         k++;
      end
      exp_q.push_back(e);
   end

   // Monitor
   always @(negedge clk) begin
      logic [12:0] e, a;
      if (load_ack === 1'b1) ack_cnt++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {load_ack, an, ca, cb, cc, cd, ce, cf, cg, dp};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL pins t=%0t k=%0d got ack/an/seg/dp=%b/%b/%b/%b want %b/%b/%b/%b",
                     $time, k, a[12], a[11:8], a[7:1], a[0], e[12], e[11:8], e[7:1], e[0]);
         end
      end
   end

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Returns at a falling edge where the next rising edge is frame position ph.
   task automatic wait_ph(input int ph);
      int n = 0;
      @(negedge clk);
      while ((k % FRAME) != ph && n < 4 * FRAME) begin
         @(negedge clk);
         n++;
      end
      if ((k % FRAME) != ph) begin
         errors++;
         $display("FAIL wait_ph timeout got phase %0d want %0d", k % FRAME, ph);
      end
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
      digits_in = d; blank_in = b; dp_in = p; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic check_acks(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   initial begin
      int a0;
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0;
      // 1: reset, then dark with nothing loaded
      cyc(3);
      reset_n = 1'b1;
      cyc(100);
      check_acks("no_load_ack", ack_cnt, 0);

      // 2: first real content
      do_load(16'h1234, 4'h0, 4'b0001);
      cyc(200);
      check_acks("single_ack", ack_cnt, 1);

      // 4: two loads in one frame, latest wins
      wait_ph(5);
      a0 = ack_cnt;
      do_load(16'hAAAA, 4'h0, 4'h0);
      wait_ph(20);
      do_load(16'h5555, 4'h0, 4'h0);
      cyc(FRAME);
      check_acks("latest_wins_acks", ack_cnt - a0, 1);
      cyc(FRAME);

      // 5: load mid-frame, then another exactly on the boundary
      wait_ph(30);
      a0 = ack_cnt;
      do_load(16'h1111, 4'h0, 4'h0);
      wait_ph(FRAME - 1);
      do_load(16'h8888, 4'h0, 4'hF);
      cyc(2 * FRAME);
      check_acks("boundary_load_acks", ack_cnt - a0, 2);

      // 6: partial blanking, then reset mid-slot 2
      do_load(16'h9C7E, 4'b0101, 4'b1010);
      cyc(2 * FRAME);
      wait_ph(2 * SLOT + 6);
      reset_n = 1'b0;
      cyc(1);
      reset_n = 1'b1;
      cyc(2 * FRAME);

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         cyc($urandom_range(1, 90));
         do_load(16'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0, 4'($urandom));
         if ($urandom_range(0, 9) == 0) begin
            reset_n = 1'b0;
            cyc($urandom_range(1, 3));
            reset_n = 1'b1;
         end
      end
      cyc(2 * FRAME);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
